// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder evaluation per clock, LSB first, with a
// registered carry and a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             c;

    // Full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | ((x ^ y) & ci), x ^ y ^ ci};
    endfunction

    assign {c, s} = full_add(a_sh[0], b_sh[0], carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        sum_sh <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum_sh <= {s, sum_sh[WIDTH-1:1]};
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    carry  <= c;
                    cnt    <= cnt + 1'b1;
                    // Last bit: publish the result and free the adder in the same edge.
                    if (cnt == LAST) begin
                        sum   <= {s, sum_sh[WIDTH-1:1]};
                        cout  <= c;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table and corner sequences on a
// WIDTH=8 instance, exhaustive sweep on a WIDTH=4 instance, queue scoreboard.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int checks = 0;
    int failures = 0;
    int done8_cnt = 0;
    int done4_cnt = 0;
    logic done8_prev = 1'b0;
    logic done4_prev = 1'b0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pops the oldest expected {cout,sum}.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            done8_cnt++;
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL done8_unexpected actual={cout,sum}=0x%0h expected=no done", {cout8, sum8});
            end else begin
                logic [8:0] e8;
                e8 = q8.pop_front();
                if ({cout8, sum8} !== e8) begin
                    failures++;
                    $display("FAIL result8 actual=0x%0h expected=0x%0h", {cout8, sum8}, e8);
                end
            end
            if (done8_prev === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL done8_width actual=2+ cycles expected=1 cycle");
            end
        end
        if (done4 === 1'b1) begin
            done4_cnt++;
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL done4_unexpected actual={cout,sum}=0x%0h expected=no done", {cout4, sum4});
            end else begin
                logic [4:0] e4;
                e4 = q4.pop_front();
                if ({cout4, sum4} !== e4) begin
                    failures++;
                    $display("FAIL result4 actual=0x%0h expected=0x%0h", {cout4, sum4}, e4);
                end
            end
        end
        done8_prev = done8;
        done4_prev = done4;
    end

    // One full transaction on the 8-bit instance with latency/busy/pulse checks.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic [8:0] exp);
        int lat;
        logic busy_ok;
        @(posedge clk); #1;
        start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
        q8.push_back(exp);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~av; b8 = ~bv; cin8 = ~cv;
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) lat = k;
            else if (busy8 !== 1'b1) busy_ok = 1'b0;
        end
        check("latency8", lat, 9);
        check("busy8_during", busy_ok, 1);
        check("busy8_in_done", busy8, 0);
        @(negedge clk);
        check("done8_pulse", done8, 0);
    endtask

    initial begin
        vec_t tbl[9];
        int d0;
        int lat;
        logic hold_ok;

        tbl[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        tbl[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        tbl[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tbl[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #12;
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_sum", sum8, 0);
        check("reset_cout", cout8, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run8(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].exp_cout, tbl[i].exp_sum});

        // Start while busy must be ignored.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        q8.push_back(9'h030);
        d0 = done8_cnt;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (30) @(negedge clk);
        check("ignore_done_count", done8_cnt - d0, 1);
        check("ignore_sum", sum8, 8'h30);
        check("ignore_queue_empty", q8.size(), 0);

        // Back-to-back with start held high; second accept lands in the done cycle.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
        q8.push_back(9'h002);
        q8.push_back(9'h100);
        @(posedge clk); #1;
        a8 = 8'h80; b8 = 8'h80;
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) lat = k;
        end
        check("b2b_first_latency", lat, 9);
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        hold_ok = 1'b1;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) lat = k;
            else if (sum8 !== 8'h02) hold_ok = 1'b0;
        end
        check("b2b_second_latency", lat, 9);
        check("b2b_sum_hold", hold_ok, 1);

        // Asynchronous reset in the middle of an operation.
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy8, 0);
        check("midrst_done", done8, 0);
        check("midrst_sum", sum8, 0);
        check("midrst_cout", cout8, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        d0 = done8_cnt;
        repeat (20) @(negedge clk);
        check("midrst_no_done", done8_cnt - d0, 0);
        run8(8'h7F, 8'h01, 1'b0, 9'h080);

        // Exhaustive sweep of the 4-bit instance against a + b + cin.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] iv;
            int seen;
            iv = i[8:0];
            @(posedge clk); #1;
            start4 = 1'b1; a4 = iv[3:0]; b4 = iv[7:4]; cin4 = iv[8];
            q4.push_back({1'b0, iv[3:0]} + {1'b0, iv[7:4]} + {4'b0, iv[8]});
            @(posedge clk); #1;
            start4 = 1'b0;
            seen = 0;
            for (int k = 1; k <= 12 && seen == 0; k++) begin
                @(negedge clk);
                if (done4 === 1'b1) seen = 1;
            end
        end
        repeat (2) @(negedge clk);
        check("sweep4_done_count", done4_cnt, 512);
        check("sweep4_queue_empty", q4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
